board_cursor_attack_ctrl: RTL and testbench

- Cursor and attack-commit controller for an N×N turn-based board game with up to P players.
- Tracks the active player's cursor and validates manual attacks against the board state.
- On turn timeout, places an automatic attack on a random empty cell, scanning forward when the random pick is occupied.
- Sits between the debounced button inputs, the turn FSM (which supplies the enables and consumes the done pulses) and the board register file.

---
 rtl/board_cursor_attack_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_board_cursor_attack_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_cursor_attack_ctrl.sv
// -----------------------------------------------------------------------------
// board_cursor_attack_ctrl
//
// Cursor and attack-commit controller for an N x N turn-based board game with
// up to P players. It moves the active player's cursor from the debounced
// buttons and checks a manual attack against the board. When the turn times
// out, it places an automatic attack on the first empty cell at or after a
// random start index.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-low reset
//   move_fwd      button level; a rising edge moves the cursor +1 (wraps)
//   move_back     button level; a rising edge moves the cursor -1 (wraps)
//   attack        button level; a rising edge commits an attack at the cursor
//   timeout       single-cycle pulse from the turn timer
//   rand_idx      random cell index, sampled on timeout
//   en_attack     one-hot turn enable (zero or multi-hot = nobody active)
//   board         flattened board, cell i at [i*CELL_W +: CELL_W], 0 = empty
//   row, col      cursor position (combinational from the cursor register)
//   end_attack    one-cycle pulse on the bit of the player whose attack landed
//   attack_idx    cell index of the accepted attack, valid with end_attack
//   attack_reject one-cycle pulse when a manual attack hits an occupied cell
//   board_full    one-cycle pulse when the timeout scan finds no empty cell
// -----------------------------------------------------------------------------
module board_cursor_attack_ctrl #(
    parameter  int N      = 3,
    parameter  int P      = 2,
    parameter  int CELL_W = 2,
    localparam int CELLS  = N * N,
    localparam int IDX_W  = $clog2(CELLS),
    localparam int POS_W  = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      move_fwd,
    input  logic                      move_back,
    input  logic                      attack,
    input  logic                      timeout,
    input  logic [IDX_W-1:0]          rand_idx,
    input  logic [P-1:0]              en_attack,
    input  logic [CELLS*CELL_W-1:0]   board,
    output logic [POS_W-1:0]          row,
    output logic [POS_W-1:0]          col,
    output logic [P-1:0]              end_attack,
    output logic [IDX_W-1:0]          attack_idx,
    output logic                      attack_reject,
    output logic                      board_full
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] cursor_q;
    logic [IDX_W-1:0] scan_q;
    logic [IDX_W-1:0] cnt_q;
    logic [P-1:0]     player_q;
    logic [P-1:0]     end_attack_q;
    logic [IDX_W-1:0] attack_idx_q;
    logic             reject_q;
    logic             full_q;

    // Previous button levels for rising-edge detection.
    logic             fwd_q;
    logic             back_q;
    logic             atk_q;

    logic             fwd_edge;
    logic             back_edge;
    logic             atk_edge;
    logic             en_valid;
    logic [CELLS-1:0] occupied;
    logic [IDX_W-1:0] move_cursor_d;
    logic [IDX_W-1:0] scan_next_d;
    logic [IDX_W-1:0] scan_start_d;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        fwd_edge  = move_fwd  & ~fwd_q;
        back_edge = move_back & ~back_q;
        atk_edge  = attack    & ~atk_q;
        en_valid  = $onehot(en_attack);

        // One occupancy bit per cell; any non-zero cell value is occupied.
        occupied = '0;
        for (int i = 0; i < CELLS; i++) begin
            occupied[i] = |board[i*CELL_W +: CELL_W];
        end

        // Cursor after a button move; simultaneous fwd and back cancel out.
        move_cursor_d = cursor_q;
        if (fwd_edge && !back_edge) begin
            move_cursor_d = (cursor_q == LAST_IDX) ? '0 : cursor_q + ONE_IDX;
        end else if (back_edge && !fwd_edge) begin
            move_cursor_d = (cursor_q == '0) ? LAST_IDX : cursor_q - ONE_IDX;
        end

        scan_next_d = (scan_q == LAST_IDX) ? '0 : scan_q + ONE_IDX;

        // An out-of-range random index folds back once: rand_idx - CELLS.
        scan_start_d = rand_idx;
        if (rand_idx > LAST_IDX) begin
            scan_start_d = rand_idx - LAST_IDX - ONE_IDX;
        end
    end

    // -------------------------------------------------------------------------
    // Button edge registers: they track the raw levels in every state, so a
    // button held through a busy phase or an enable change never re-fires.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_q  <= 1'b0;
            back_q <= 1'b0;
            atk_q  <= 1'b0;
        end else begin
            fwd_q  <= move_fwd;
            back_q <= move_back;
            atk_q  <= attack;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: every control flop, including scan index, counter and latched
    // player, is in the async reset, so a reset mid-scan leaves no stale
    // state behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cursor_q     <= '0;
            scan_q       <= '0;
            cnt_q        <= '0;
            player_q     <= '0;
            end_attack_q <= '0;
            attack_idx_q <= '0;
            reject_q     <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            // Result outputs are pulses: cleared unless set below this cycle.
            end_attack_q <= '0;
            attack_idx_q <= '0;
            reject_q     <= 1'b0;
            full_q       <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // Priority: timeout > attack edge > move edge.
                    if (en_valid) begin
                        if (timeout) begin
                            scan_q   <= scan_start_d;
                            cnt_q    <= '0;
                            player_q <= en_attack;
                            state_q  <= S_SCAN;
                        end else if (atk_edge) begin
                            if (!occupied[cursor_q]) begin
                                end_attack_q <= en_attack;
                                attack_idx_q <= cursor_q;
                                state_q      <= S_DONE;
                            end else begin
                                reject_q <= 1'b1;
                            end
                        end else begin
                            cursor_q <= move_cursor_d;
                        end
                    end
                end

                S_SCAN: begin
                    // One cell per cycle; the player latched at timeout is
                    // credited even if the enable has moved on since.
                    if (!occupied[scan_q]) begin
                        end_attack_q <= player_q;
                        attack_idx_q <= scan_q;
                        cursor_q     <= scan_q;
                        state_q      <= S_DONE;
                    end else if (cnt_q == LAST_IDX) begin
                        full_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        scan_q <= scan_next_d;
                        cnt_q  <= cnt_q + ONE_IDX;
                    end
                end

                S_DONE: begin
                    // Gap cycle after a commit; all requests are dropped.
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign row           = POS_W'(cursor_q / N_IDX);
    assign col           = POS_W'(cursor_q % N_IDX);
    assign end_attack    = end_attack_q;
    assign attack_idx    = attack_idx_q;
    assign attack_reject = reject_q;
    assign board_full    = full_q;

endmodule

// File: tb/tb_board_cursor_attack_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for board_cursor_attack_ctrl (N=3, P=2, CELL_W=2).
// A table of directed vectors, hand-written multi-cycle sequences, and a
// randomized phase compared against a behavioural model of the controller.
// -----------------------------------------------------------------------------
module tb_board_cursor_attack_ctrl;

    localparam int N      = 3;
    localparam int P      = 2;
    localparam int CELL_W = 2;
    localparam int CELLS  = N * N;
    localparam int IDX_W  = $clog2(CELLS);
    localparam int POS_W  = $clog2(N);
    localparam int BRD_W  = CELLS * CELL_W;

    localparam logic [BRD_W-1:0] BRD_EMPTY = '0;
    localparam logic [BRD_W-1:0] BRD_FULL  = 18'h15555;

    logic                 clk;
    logic                 rst;
    logic                 move_fwd;
    logic                 move_back;
    logic                 attack;
    logic                 timeout;
    logic [IDX_W-1:0]     rand_idx;
    logic [P-1:0]         en_attack;
    logic [BRD_W-1:0]     board;
    logic [POS_W-1:0]     row;
    logic [POS_W-1:0]     col;
    logic [P-1:0]         end_attack;
    logic [IDX_W-1:0]     attack_idx;
    logic                 attack_reject;
    logic                 board_full;

    int checks = 0;
    int errors = 0;

    board_cursor_attack_ctrl #(
        .N      (N),
        .P      (P),
        .CELL_W (CELL_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .move_fwd      (move_fwd),
        .move_back     (move_back),
        .attack        (attack),
        .timeout       (timeout),
        .rand_idx      (rand_idx),
        .en_attack     (en_attack),
        .board         (board),
        .row           (row),
        .col           (col),
        .end_attack    (end_attack),
        .attack_idx    (attack_idx),
        .attack_reject (attack_reject),
        .board_full    (board_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int erow, input int ecol,
                              input logic [P-1:0] eend, input logic [IDX_W-1:0] eidx,
                              input logic erej, input logic efull);
        check({tag, ".row"},    32'(row),           32'(erow));
        check({tag, ".col"},    32'(col),           32'(ecol));
        check({tag, ".end"},    32'(end_attack),    32'(eend));
        check({tag, ".idx"},    32'(attack_idx),    32'(eidx));
        check({tag, ".reject"}, 32'(attack_reject), 32'(erej));
        check({tag, ".full"},   32'(board_full),    32'(efull));
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        move_fwd  = 1'b0;
        move_back = 1'b0;
        attack    = 1'b0;
        timeout   = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [CELL_W-1:0] cell_of(input logic [BRD_W-1:0] b, input int i);
        return b[i*CELL_W +: CELL_W];
    endfunction

    // -------------------------------------------------------------------------
    // Behavioural model: a pending timeout is resolved at once by searching
    // the board, then replayed as a countdown to the cycle the result appears.
    // -------------------------------------------------------------------------
    int             m_cursor;
    int             m_wait;       // edges left until the timeout result
    bit             m_ignore;     // next edge is the post-commit gap
    bit             m_found;
    int             m_target;
    logic [P-1:0]   m_player;
    bit             m_pf, m_pb, m_pa;
    logic [P-1:0]   x_end;
    logic [IDX_W-1:0] x_idx;
    logic           x_rej, x_full;

    task automatic model_reset();
        m_cursor = 0;
        m_wait   = 0;
        m_ignore = 0;
        m_found  = 0;
        m_target = 0;
        m_player = '0;
        m_pf = 0; m_pb = 0; m_pa = 0;
        x_end = '0; x_idx = '0; x_rej = 0; x_full = 0;
    endtask

    // Call with this cycle's inputs driven; predicts outputs after the edge.
    task automatic model_step();
        bit fe, be, ae;
        int start, k;
        fe = move_fwd  && !m_pf;
        be = move_back && !m_pb;
        ae = attack    && !m_pa;
        m_pf = move_fwd; m_pb = move_back; m_pa = attack;
        x_end = '0; x_idx = '0; x_rej = 0; x_full = 0;
        if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                if (m_found) begin
                    x_end    = m_player;
                    x_idx    = IDX_W'(m_target);
                    m_cursor = m_target;
                    m_ignore = 1;
                end else begin
                    x_full = 1;
                end
            end
        end else if (m_ignore) begin
            m_ignore = 0;
        end else if ($countones(en_attack) == 1) begin
            if (timeout) begin
                start = (int'(rand_idx) >= CELLS) ? int'(rand_idx) - CELLS : int'(rand_idx);
                k = -1;
                for (int j = 0; j < CELLS; j++) begin
                    if (k < 0 && cell_of(board, (start + j) % CELLS) == '0) k = j;
                end
                m_player = en_attack;
                if (k >= 0) begin
                    m_found  = 1;
                    m_target = (start + k) % CELLS;
                    m_wait   = k + 1;
                end else begin
                    m_found = 0;
                    m_wait  = CELLS;
                end
            end else if (ae) begin
                if (cell_of(board, m_cursor) == '0) begin
                    x_end    = en_attack;
                    x_idx    = IDX_W'(m_cursor);
                    m_ignore = 1;
                end else begin
                    x_rej = 1;
                end
            end else if (fe && !be) begin
                m_cursor = (m_cursor + 1) % CELLS;
            end else if (be && !fe) begin
                m_cursor = (m_cursor + CELLS - 1) % CELLS;
            end
        end
    endtask

    function automatic logic [BRD_W-1:0] rand_board();
        logic [BRD_W-1:0] b;
        int level;
        b = '0;
        level = int'($urandom_range(0, 4));
        for (int i = 0; i < CELLS; i++) begin
            if (level == 4 || int'($urandom_range(0, 3)) < level) begin
                b[i*CELL_W +: CELL_W] = CELL_W'($urandom_range(1, 3));
            end
        end
        return b;
    endfunction

    // -------------------------------------------------------------------------
    // Directed vector table
    // -------------------------------------------------------------------------
    typedef struct {
        logic             fwd;
        logic             back;
        logic             atk;
        logic [P-1:0]     en;
        logic [BRD_W-1:0] brd;
        int               erow;
        int               ecol;
        logic [P-1:0]     eend;
        logic [IDX_W-1:0] eidx;
        logic             erej;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic f, input logic b, input logic a, input logic [P-1:0] en,
                           input logic [BRD_W-1:0] brd, input int pos,
                           input logic [P-1:0] eend, input int eidx, input logic erej);
        vec_t v;
        v.fwd = f; v.back = b; v.atk = a; v.en = en; v.brd = brd;
        v.erow = pos / N; v.ecol = pos % N;
        v.eend = eend; v.eidx = IDX_W'(eidx); v.erej = erej;
        vecs.push_back(v);
    endtask

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        int lat;
        int end_seen;
        int pos;
        bit seen;

        rst = 1'b0;
        drive_idle();
        rand_idx  = '0;
        en_attack = 2'b01;
        board     = BRD_EMPTY;

        // Walk forward through all 9 cells and wrap, then back from 0.
        for (int k = 1; k <= CELLS; k++) begin
            add_vec(1, 0, 0, 2'b01, BRD_EMPTY, k % CELLS, '0, 0, 0);
            add_vec(0, 0, 0, 2'b01, BRD_EMPTY, k % CELLS, '0, 0, 0);
        end
        add_vec(0, 1, 0, 2'b01, BRD_EMPTY, 8, '0, 0, 0);
        add_vec(0, 0, 0, 2'b01, BRD_EMPTY, 8, '0, 0, 0);
        for (int k = 7; k >= 4; k--) begin
            add_vec(0, 1, 0, 2'b01, BRD_EMPTY, k, '0, 0, 0);
            add_vec(0, 0, 0, 2'b01, BRD_EMPTY, k, '0, 0, 0);
        end
        // No active player / multi-hot enable: requests ignored.
        add_vec(1, 0, 0, 2'b00, BRD_EMPTY, 4, '0, 0, 0);
        add_vec(0, 0, 0, 2'b00, BRD_EMPTY, 4, '0, 0, 0);
        add_vec(0, 0, 1, 2'b11, BRD_EMPTY, 4, '0, 0, 0);
        add_vec(0, 0, 0, 2'b11, BRD_EMPTY, 4, '0, 0, 0);
        // Accepted manual attack at cell 4, then a move during DONE is dropped.
        add_vec(0, 0, 1, 2'b01, BRD_EMPTY, 4, 2'b01, 4, 0);
        add_vec(1, 0, 0, 2'b01, BRD_EMPTY, 4, '0, 0, 0);
        add_vec(0, 0, 0, 2'b01, BRD_EMPTY, 4, '0, 0, 0);
        // Rejected attack on occupied cell 4 by player 1; still IDLE afterwards.
        add_vec(0, 0, 1, 2'b10, 18'h00100, 4, '0, 0, 1);
        add_vec(0, 0, 0, 2'b10, 18'h00100, 4, '0, 0, 0);
        add_vec(1, 0, 0, 2'b10, 18'h00100, 5, '0, 0, 0);
        add_vec(0, 0, 0, 2'b10, 18'h00100, 5, '0, 0, 0);

        do_reset();
        check_outs("reset", 0, 0, '0, '0, 0, 0);

        foreach (vecs[i]) begin
            move_fwd  = vecs[i].fwd;
            move_back = vecs[i].back;
            attack    = vecs[i].atk;
            en_attack = vecs[i].en;
            board     = vecs[i].brd;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].erow, vecs[i].ecol,
                       vecs[i].eend, vecs[i].eidx, vecs[i].erej, 1'b0);
        end

        // Timeout scan: cells 7,8 occupied, start 7 -> lands on 0 after 3 cycles.
        do_reset();
        en_attack = 2'b01;
        board     = 18'h14000;
        rand_idx  = 4'd7;
        timeout   = 1'b1;
        tick();
        timeout = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (end_attack != '0) begin
                lat = c;
                break;
            end
        end
        check("scan_wrap.latency", 32'(lat), 32'd3);
        check_outs("scan_wrap", 0, 0, 2'b01, '0, 0, 0);
        tick();
        check("scan_wrap.clear", 32'(end_attack), 32'd0);

        // Out-of-range rand_idx 13 folds to 4; only cell 5 empty.
        board    = 18'h15155;
        rand_idx = 4'd13;
        timeout  = 1'b1;
        tick();
        timeout = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (end_attack != '0) begin
                lat = c;
                break;
            end
        end
        check("scan_fold.latency", 32'(lat), 32'd2);
        check_outs("scan_fold", 1, 2, 2'b01, 4'd5, 0, 0);

        // Full board: board_full after CELLS cycles, no attack committed.
        tick();
        board    = BRD_FULL;
        rand_idx = 4'd4;
        timeout  = 1'b1;
        tick();
        timeout  = 1'b0;
        lat      = 0;
        end_seen = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (end_attack != '0) end_seen++;
            if (board_full) begin
                lat = c;
                break;
            end
        end
        check("full.latency", 32'(lat), 32'd9);
        check("full.no_end", 32'(end_seen), 32'd0);
        tick();
        check("full.clear", 32'(board_full), 32'd0);

        // Timeout and attack edge together: timeout wins (scan from 6).
        do_reset();
        en_attack = 2'b01;
        board     = BRD_EMPTY;
        rand_idx  = 4'd6;
        timeout   = 1'b1;
        attack    = 1'b1;
        tick();
        timeout = 1'b0;
        check("tmo_vs_atk.end0", 32'(end_attack), 32'd0);
        check("tmo_vs_atk.rej0", 32'(attack_reject), 32'd0);
        tick();
        check_outs("tmo_vs_atk", 2, 0, 2'b01, 4'd6, 0, 0);
        attack = 1'b0;
        tick();
        tick();

        // Reset during a long scan aborts it immediately.
        board    = 18'h05555;
        rand_idx = 4'd0;
        timeout  = 1'b1;
        tick();
        timeout = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_outs("mid_reset", 0, 0, '0, '0, 0, 0);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (end_attack != '0 || board_full) seen = 1;
        end
        check("mid_reset.aborted", 32'(seen), 32'd0);

        // Randomized phase against the behavioural model.
        do_reset();
        model_reset();
        board = BRD_EMPTY;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (m_wait == 0 && $urandom_range(0, 7) == 0) board = rand_board();
            if ($urandom_range(0, 2) == 0) move_fwd  = ~move_fwd;
            if ($urandom_range(0, 2) == 0) move_back = ~move_back;
            if ($urandom_range(0, 3) == 0) attack    = ~attack;
            timeout  = ($urandom_range(0, 19) == 0);
            rand_idx = IDX_W'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0:       en_attack = 2'b00;
                1:       en_attack = 2'b11;
                default: en_attack = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            endcase
            model_step();
            pos = m_cursor;
            tick();
            check_outs($sformatf("rand%0d", cyc), pos / N, pos % N, x_end, x_idx, x_rej, x_full);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
